// File: rtl/batalha_naval_pkg.sv
// Shared definitions for the battleship game core.
//   state_t         : game state encoding (also driven onto the 2-bit state port)
//   DEF_*           : default geometry and shot budget of the board
//   RW/CW/SW/HW     : row/column/shot-counter/hit-counter widths for the default board
//   idx(r, c, cols) : linear cell index, bit r*cols+c of the ship/attack maps
package batalha_naval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_POSITION = 2'b01,
    ST_ATTACK   = 2'b10,
    ST_END      = 2'b11
  } state_t;

  localparam int DEF_ROWS      = 7;
  localparam int DEF_COLS      = 5;
  localparam int DEF_MAX_SHOTS = 15;

  localparam int RW = $clog2(DEF_ROWS);
  localparam int CW = $clog2(DEF_COLS);
  localparam int SW = $clog2(DEF_MAX_SHOTS + 1);
  localparam int HW = $clog2(DEF_ROWS * DEF_COLS + 1);

  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/batalha_naval_scan.sv
// Column scanner for the LED matrix.
//   clk, clr : clock, asynchronous active-high reset
//   col_next : column index that m_col will show after the coming edge; the
//              core uses it to register m_line on the same edge as m_col
//   m_col    : registered one-hot, active-high column select
// One column advance per 2**SCAN_DIV clocks; column COLS-1 wraps to 0.
module batalha_naval_scan #(
  parameter int COLS     = 5,
  parameter int SCAN_DIV = 16
) (
  input  logic                    clk,
  input  logic                    clr,
  output logic [$clog2(COLS)-1:0] col_next,
  output logic [COLS-1:0]         m_col
);

  localparam int COL_W = $clog2(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  logic [SCAN_DIV-1:0] presc_reg;
  logic [COL_W-1:0]    col_reg;
  logic [COLS-1:0]     m_col_next;
  logic                presc_wrap;

  assign presc_wrap = &presc_reg;

  always_comb begin
    col_next = col_reg;
    if (presc_wrap) begin
      col_next = (col_reg == LAST_COL) ? '0 : col_reg + COL_W'(1);
    end
  end

  genvar gi;
  for (gi = 0; gi < COLS; gi++) begin : g_onehot
    assign m_col_next[gi] = (col_next == COL_W'(gi));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_reg <= '0;
      col_reg   <= '0;
      m_col     <= COLS'(1);
    end else begin
      presc_reg <= presc_reg + SCAN_DIV'(1);
      col_reg   <= col_next;
      m_col     <= m_col_next;
    end
  end

endmodule

// File: rtl/batalha_naval_ctrl.sv
// Battleship game core for a ROWS x COLS LED matrix.
//   clk, clr        : clock, asynchronous active-high reset (aborts any game)
//   start, confirm  : 1-cycle pulses; start = new game/restart, confirm = load layout / fire
//   ship_map        : layout, bit r*COLS+c = ship at (r, c)
//   at_row, at_col  : attack coordinates (may be out of range)
//   state           : 00 IDLE, 01 POSITION, 10 ATTACK, 11 END
//   m_col, m_line   : matrix column select (one-hot) and line data for that column
//   rgb_r, rgb_g    : last valid shot missed / hit
//   shot_err        : 1-cycle pulse on an empty layout, repeated or out-of-range shot
//   shots_left, hits: shot budget remaining, hits so far
//   game_over, win  : END reached, and whether every ship was sunk
// All outputs are registered.
module batalha_naval_ctrl
  import batalha_naval_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int MAX_SHOTS = DEF_MAX_SHOTS,
  parameter int SCAN_DIV  = 16
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               start,
  input  logic                               confirm,
  input  logic [ROWS*COLS-1:0]               ship_map,
  input  logic [$clog2(ROWS)-1:0]            at_row,
  input  logic [$clog2(COLS)-1:0]            at_col,
  output logic [1:0]                         state,
  output logic [COLS-1:0]                    m_col,
  output logic [ROWS-1:0]                    m_line,
  output logic                               rgb_r,
  output logic                               rgb_g,
  output logic                               shot_err,
  output logic [$clog2(MAX_SHOTS+1)-1:0]     shots_left,
  output logic [$clog2(ROWS*COLS+1)-1:0]     hits,
  output logic                               game_over,
  output logic                               win
);

  localparam int N      = ROWS * COLS;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int SHOT_W = $clog2(MAX_SHOTS + 1);
  localparam int HIT_W  = $clog2(N + 1);
  localparam int IDX_W  = $clog2(N);

  localparam logic [ROW_W:0]    ROWS_V = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0]    COLS_V = (COL_W + 1)'(COLS);
  localparam logic [SHOT_W-1:0] MAX_V  = SHOT_W'(MAX_SHOTS);

  state_t            state_reg, state_next;
  logic [N-1:0]      pos_reg, pos_next;
  logic [N-1:0]      atk_reg, atk_next;
  logic [HIT_W-1:0]  ship_cnt_reg, ship_cnt_next;
  logic [HIT_W-1:0]  hits_reg, hits_next;
  logic [SHOT_W-1:0] shots_reg, shots_next;
  logic              rgb_r_reg, rgb_r_next;
  logic              rgb_g_reg, rgb_g_next;
  logic              shot_err_reg, shot_err_next;
  logic              win_reg, win_next;
  logic [ROWS-1:0]   m_line_reg, m_line_next;

  logic [HIT_W-1:0]  map_cnt;
  logic [IDX_W-1:0]  shot_idx;
  logic              out_of_range, already_shot, hit_cell;
  logic [HIT_W-1:0]  hits_inc;
  logic [SHOT_W-1:0] shots_dec;
  logic [N-1:0]      disp_map;
  logic [COL_W-1:0]  col_next;

  batalha_naval_scan #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .clr      (clr),
    .col_next (col_next),
    .m_col    (m_col)
  );

  // Popcount of the layout currently presented on ship_map.
  always_comb begin
    map_cnt = '0;
    for (int i = 0; i < N; i++) begin
      map_cnt = map_cnt + HIT_W'(ship_map[i]);
    end
  end

  // Shot decode. shot_idx is only meaningful when the coordinates are in range.
  assign out_of_range = ({1'b0, at_row} >= ROWS_V) || ({1'b0, at_col} >= COLS_V);
  assign shot_idx     = IDX_W'(idx(32'(at_row), 32'(at_col), COLS));
  assign already_shot = atk_reg[shot_idx];
  assign hit_cell     = pos_reg[shot_idx];
  assign hits_inc     = hits_reg + HIT_W'(hit_cell);
  assign shots_dec    = shots_reg - SHOT_W'(1);

  // State register together with the game datapath.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg    <= ST_IDLE;
      pos_reg      <= '0;
      atk_reg      <= '0;
      ship_cnt_reg <= '0;
      hits_reg     <= '0;
      shots_reg    <= MAX_V;
      rgb_r_reg    <= 1'b0;
      rgb_g_reg    <= 1'b0;
      shot_err_reg <= 1'b0;
      win_reg      <= 1'b0;
      m_line_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pos_reg      <= pos_next;
      atk_reg      <= atk_next;
      ship_cnt_reg <= ship_cnt_next;
      hits_reg     <= hits_next;
      shots_reg    <= shots_next;
      rgb_r_reg    <= rgb_r_next;
      rgb_g_reg    <= rgb_g_next;
      shot_err_reg <= shot_err_next;
      win_reg      <= win_next;
      m_line_reg   <= m_line_next;
    end
  end

  // Next-state and datapath update. start overrides confirm in every state.
  always_comb begin
    state_next    = state_reg;
    pos_next      = pos_reg;
    atk_next      = atk_reg;
    ship_cnt_next = ship_cnt_reg;
    hits_next     = hits_reg;
    shots_next    = shots_reg;
    rgb_r_next    = rgb_r_reg;
    rgb_g_next    = rgb_g_reg;
    win_next      = win_reg;
    shot_err_next = 1'b0;

    if (start) begin
      state_next = ST_POSITION;
      atk_next   = '0;
      hits_next  = '0;
      shots_next = MAX_V;
      rgb_r_next = 1'b0;
      rgb_g_next = 1'b0;
      win_next   = 1'b0;
    end else if (confirm) begin
      case (state_reg)
        ST_POSITION: begin
          pos_next      = ship_map;
          ship_cnt_next = map_cnt;
          if (map_cnt == '0) begin
            shot_err_next = 1'b1;
          end else begin
            state_next = ST_ATTACK;
            atk_next   = '0;
            hits_next  = '0;
            shots_next = MAX_V;
            rgb_r_next = 1'b0;
            rgb_g_next = 1'b0;
          end
        end
        ST_ATTACK: begin
          if (out_of_range || already_shot) begin
            shot_err_next = 1'b1;
          end else begin
            atk_next[shot_idx] = 1'b1;
            shots_next         = shots_dec;
            hits_next          = hits_inc;
            rgb_g_next         = hit_cell;
            rgb_r_next         = !hit_cell;
            // Sinking the last ship wins even if the budget ran out on the same shot.
            if (hits_inc == ship_cnt_reg) begin
              state_next = ST_END;
              win_next   = 1'b1;
            end else if (shots_dec == '0) begin
              state_next = ST_END;
              win_next   = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Display content is taken from the post-edge state so that m_line lands on
  // the same edge as the matching m_col, and the port drives.
  always_comb begin
    case (state_next)
      ST_IDLE:     disp_map = '0;
      ST_POSITION: disp_map = ship_map;
      ST_ATTACK:   disp_map = atk_next & pos_next;
      default:     disp_map = pos_next | atk_next;
    endcase
    state      = state_reg;
    game_over  = (state_reg == ST_END);
    win        = win_reg;
    rgb_r      = rgb_r_reg;
    rgb_g      = rgb_g_reg;
    shot_err   = shot_err_reg;
    shots_left = shots_reg;
    hits       = hits_reg;
    m_line     = m_line_reg;
  end

  genvar gi;
  for (gi = 0; gi < ROWS; gi++) begin : g_line
    logic [COLS-1:0] row_bits;
    assign row_bits        = disp_map[gi*COLS +: COLS];
    assign m_line_next[gi] = row_bits[col_next];
  end

endmodule

// File: tb/tb_batalha_naval_ctrl.sv
// Scoreboard bench: the driver applies one cycle of stimulus per negedge,
// updates a game-rule reference model and queues the expected outputs for the
// following negedge; an independent monitor pops and compares them.
module tb_batalha_naval_ctrl;

  localparam int ROWS = 7, COLS = 5, MAX_SHOTS = 3, SCAN_DIV = 2;
  localparam int N = ROWS * COLS;
  localparam int SCAN_PERIOD = 4;  // 2**SCAN_DIV

  logic           clk = 1'b0, clr = 1'b1, start = 1'b0, confirm = 1'b0;
  logic [N-1:0]   ship_map = '0;
  logic [2:0]     at_row = '0, at_col = '0;
  logic [1:0]     state;
  logic [COLS-1:0] m_col;
  logic [ROWS-1:0] m_line;
  logic           rgb_r, rgb_g, shot_err, game_over, win;
  logic [1:0]     shots_left;
  logic [5:0]     hits;

  batalha_naval_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .MAX_SHOTS(MAX_SHOTS), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .confirm(confirm), .ship_map(ship_map),
    .at_row(at_row), .at_col(at_col), .state(state), .m_col(m_col), .m_line(m_line),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .shot_err(shot_err), .shots_left(shots_left),
    .hits(hits), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          verbose;
    string       tag;
    logic [26:0] v;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;

  // Reference model: plain game rules over bit sets and integers.
  bit [N-1:0] ships, shots;
  int m_st, hits_m, left_m, ship_n, x_rel;
  bit win_m, rr_m, gg_m, err_m, in_rst;

  function automatic void model_reset();
    m_st = 0; ships = '0; shots = '0; hits_m = 0; left_m = MAX_SHOTS; ship_n = 0;
    win_m = 0; rr_m = 0; gg_m = 0; err_m = 0;
  endfunction

  function automatic void model_apply(bit st, bit cf, bit [N-1:0] map, int r, int c);
    int k;
    err_m = 0;
    if (st) begin
      m_st = 1; shots = '0; hits_m = 0; left_m = MAX_SHOTS; win_m = 0; rr_m = 0; gg_m = 0;
    end else if (cf && m_st == 1) begin
      ships = map; ship_n = $countones(map);
      if (ship_n == 0) err_m = 1;
      else begin
        m_st = 2; shots = '0; hits_m = 0; left_m = MAX_SHOTS; rr_m = 0; gg_m = 0;
      end
    end else if (cf && m_st == 2) begin
      k = r * COLS + c;
      if (r >= ROWS || c >= COLS || shots[k]) err_m = 1;
      else begin
        shots[k] = 1; left_m--;
        if (ships[k]) begin hits_m++; gg_m = 1; rr_m = 0; end
        else begin gg_m = 0; rr_m = 1; end
        if (hits_m == ship_n) begin m_st = 3; win_m = 1; end
        else if (left_m == 0) begin m_st = 3; win_m = 0; end
      end
    end
  endfunction

  function automatic logic [26:0] model_vec(int due);
    int col;
    bit [N-1:0] disp;
    logic [ROWS-1:0] lines;
    logic [COLS-1:0] onehot;
    col = in_rst ? 0 : ((due - x_rel) / SCAN_PERIOD) % COLS;
    case (m_st)
      0: disp = '0;
      1: disp = ship_map;
      2: disp = ships & shots;
      default: disp = ships | shots;
    endcase
    for (int r = 0; r < ROWS; r++) lines[r] = disp[r * COLS + col];
    onehot = '0;
    onehot[col] = 1'b1;
    return {2'(m_st), onehot, lines, rr_m, gg_m, err_m, 2'(left_m), 6'(hits_m),
            1'(m_st == 3), win_m};
  endfunction

  function automatic void check(string tag, bit verbose, logic [26:0] exp);
    logic [26:0] act;
    act = {state, m_col, m_line, rgb_r, rgb_g, shot_err, shots_left, hits, game_over, win};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got st=%b col=%b line=%b rg=%b%b err=%b left=%0d hits=%0d go=%b win=%b want st=%b col=%b line=%b rg=%b%b err=%b left=%0d hits=%0d go=%b win=%b",
               tag, cyc, act[26:25], act[24:20], act[19:13], act[12], act[11], act[10],
               act[9:8], act[7:2], act[1], act[0], exp[26:25], exp[24:20], exp[19:13],
               exp[12], exp[11], exp[10], exp[9:8], exp[7:2], exp[1], exp[0]);
    end else if (verbose) begin
      $display("ok   %-14s cyc=%0d st=%b left=%0d hits=%0d rg=%b%b err=%b win=%b",
               tag, cyc, act[26:25], act[9:8], act[7:2], act[12], act[11], act[10], act[0]);
    end
  endfunction

  // Monitor: compares every queued expectation on the negedge it falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          n_cmp++; n_bad++;
          $display("FAIL stale_%s due=%0d now=%0d", e.tag, e.due, cyc);
        end else begin
          check(e.tag, e.verbose, e.v);
        end
      end
    end
  end

  // One cycle of stimulus; expected outputs after the next edge are queued.
  task automatic drive(bit rst, bit st, bit cf, logic [N-1:0] map, int r, int c, string tag);
    exp_t e;
    @(negedge clk);
    if (rst) begin
      clr = 1'b1; in_rst = 1; start = 1'b0; confirm = 1'b0;
      model_reset();
    end else begin
      if (clr) begin clr = 1'b0; in_rst = 0; x_rel = cyc; end
      start = st; confirm = cf;
    end
    ship_map = map; at_row = 3'(r); at_col = 3'(c);
    if (!rst) model_apply(st, cf, map, r, c);
    e.due = cyc + 1; e.verbose = (tag != ""); e.tag = (tag != "") ? tag : "idle"; e.v = model_vec(cyc + 1);
    q.push_back(e);
  endtask

  task automatic nops(int n, logic [N-1:0] map);
    for (int i = 0; i < n; i++) drive(0, 0, 0, map, 0, 0, "");
  endtask

  logic [N-1:0] m7, m01, rmap;
  int p, k, r, c;

  initial begin
    model_reset(); in_rst = 1; x_rel = 0;
    m7 = '0; m7[7] = 1'b1;
    m01 = '0; m01[0] = 1'b1; m01[1] = 1'b1;

    for (int i = 0; i < 3; i++) drive(1, 0, 0, '0, 0, 0, "reset");
    nops(2, '0);

    // Empty layout is rejected.
    drive(0, 0, 1, '0, 0, 0, "confirm_idle");
    drive(0, 1, 0, '0, 0, 0, "start");
    drive(0, 0, 1, '0, 0, 0, "empty_map");
    nops(2, '0);

    // Single ship at bit 7 sunk on the first shot.
    drive(0, 0, 1, m7, 0, 0, "load_m7");
    drive(0, 0, 1, m7, 1, 2, "shot_1_2_win");
    nops(3, m7);

    // Miss, repeat, miss, out of range.
    drive(0, 1, 0, m7, 0, 0, "restart_end");
    drive(0, 0, 1, m7, 0, 0, "load_m7");
    drive(0, 0, 1, m7, 0, 0, "shot_0_0");
    drive(0, 0, 1, m7, 0, 0, "shot_repeat");
    drive(0, 0, 1, m7, 6, 4, "shot_6_4");
    drive(0, 0, 1, m7, 7, 0, "shot_row7");
    drive(0, 0, 1, m7, 1, 6, "shot_col6");
    nops(2, m7);

    // Budget exhausted, then a confirm in END is ignored.
    drive(0, 1, 0, m01, 0, 0, "restart");
    drive(0, 0, 1, m01, 0, 0, "load_m01");
    drive(0, 0, 1, m01, 2, 0, "shot_10");
    drive(0, 0, 1, m01, 2, 1, "shot_11");
    drive(0, 0, 1, m01, 2, 2, "shot_12_lose");
    drive(0, 0, 1, m01, 0, 0, "confirm_end");
    nops(2, m01);

    // Live preview in POSITION across a full scan of all columns.
    rmap = {$urandom(), $urandom()};
    drive(0, 1, 0, rmap, 0, 0, "restart_prev");
    nops(24, rmap);

    // start+confirm together in ATTACK: restart wins, no shot taken.
    drive(0, 0, 1, m01, 0, 0, "load_m01");
    drive(0, 0, 1, m01, 0, 0, "shot_hit");
    drive(0, 1, 1, m01, 3, 3, "start_confirm");
    nops(2, m01);

    // Asynchronous clear mid-ATTACK.
    drive(0, 0, 1, m01, 0, 0, "load_m01");
    drive(0, 0, 1, m01, 4, 4, "shot_miss");
    nops(1, m01);
    drive(1, 0, 0, m01, 0, 0, "clr_mid_game");
    #1 check("clr_same_edge", 1, model_vec(cyc));
    for (int i = 0; i < 10; i++) drive(1, 0, 1, m01, 0, 0, "");
    nops(2, m01);

    // Randomised play.
    rmap = '0;
    for (int it = 0; it < 500; it++) begin
      p = $urandom_range(0, 99);
      if ($urandom_range(0, 4) == 0) begin
        rmap = '0;
        for (int b = $urandom_range(0, 3); b > 0; b--) rmap[$urandom_range(0, N - 1)] = 1'b1;
      end
      if (ships != '0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, N - 1);
        for (int t = 0; t < 200 && !ships[k]; t++) k = $urandom_range(0, N - 1);
        r = k / COLS; c = k % COLS;
      end else begin
        r = $urandom_range(0, 7); c = $urandom_range(0, 7);
      end
      if (p == 99)     drive(1, 0, 0, rmap, r, c, "rnd_clr");
      else if (p < 8)  drive(0, 1, 0, rmap, r, c, "rnd_start");
      else if (p < 11) drive(0, 1, 1, rmap, r, c, "rnd_start_cf");
      else if (p < 55) drive(0, 0, 1, rmap, r, c, "rnd_confirm");
      else             drive(0, 0, 0, rmap, r, c, "");
    end
    nops(2, rmap);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
